axis_pingpong_frame_buffer: RTL and testbench
=============================================

# axis_pingpong_frame_buffer

Parametrised store-and-forward AXI-Stream frame buffer with two memory banks. One frame is captured into one bank while the previously captured frame replays from the other. The block sits between the DMA MM2S stream and the convolution datapath, and replaces the single-bank, fixed-16-word capture/replay IP. Over-length frames are truncated to DEPTH words and flagged.

## Interface
- DATA_WIDTH, 32: stream data width in bits, multiple of 8.
- DEPTH, 16: words per bank; power of two, ≥ 2.
- aclk  in  1  single clock for both stream interfaces.
- areset  in  1  synchronous reset, active-high.
- s00_axis_tdata  in  DATA_WIDTH  input data.
- s00_axis_tstrb  in  DATA_WIDTH/8  input byte strobes; stored with the data.
- s00_axis_tlast  in  1  end of input frame.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input beat accepted when tvalid && tready.
- m00_axis_tdata  out  DATA_WIDTH  replayed data.
- m00_axis_tstrb  out  DATA_WIDTH/8  replayed strobes.
- m00_axis_tlast  out  1  high on the last word of the replayed frame.
- m00_axis_tvalid  out  1  output beat valid.
- m00_axis_tready  in  1  downstream ready.
- bank_full  out  2  per-bank "frame stored, not yet fully drained".
- overflow  out  1  sticky; set when any frame is truncated.

## Operation
- Each bank holds DEPTH × (DATA_WIDTH + DATA_WIDTH/8) bits plus a length register of clog2(DEPTH)+1 bits.
- Write side states:
  - FILL: wr_bank is not full. tready=1. Each accepted beat is written at wr_ptr, then wr_ptr++.
  - Close rule: a frame closes when tlast is accepted, or when the DEPTH-th word is accepted.
  - On close: len = wr_ptr+1, bank_full[wr_bank] is set, wr_bank toggles, wr_ptr returns to 0.
  - DEPTH-th word accepted without tlast: overflow is set and the state moves to DISCARD.
  - DISCARD: tready=1. Accepted beats are dropped, including the beat carrying tlast, which returns the state to FILL. Dropped beats never enter the other bank.
  - WAIT: wr_bank is full. tready=0. Return to FILL when that bank is freed.
- Read side states:
  - IDLE: when bank_full[rd_bank]=1, load output register from mem[rd_bank][0] and go to SEND.
  - SEND: tvalid=1. tlast=(rd_ptr==len-1).
    - Handshake on a non-last word: the register loads the next word in the same edge, so there are no gaps within a frame.
    - Handshake on the last word: clear bank_full[rd_bank], toggle rd_bank, go to IDLE.
- tdata, tstrb and tlast hold stable while tvalid && !tready.
- Simultaneous events:
  - A bank freed by the read side on the same edge the write side finds it full counts as free on the next cycle. The write side never overwrites a bank still draining.
  - The write side closing and the read side freeing different banks on the same edge are both honoured.
- Reset:
  - bank_full=0, pointers and banks selectors=0, FSMs to FILL/IDLE, overflow=0.
  - Output regs 0; memory contents don't care.
  - Frames in flight are discarded without tlast.

## Timing
- Reset values: s00_axis_tready=0 while areset=1 and 1 on the first cycle after. m00_axis_tvalid/tdata/tstrb/tlast=0. bank_full=0. overflow=0.
- Closing beat accepted at edge N: bank_full set after N. m00_axis_tvalid=1 after edge N+1, if the read side was IDLE on that bank.
- Throughput is 1 word/cycle on both sides.
- Exactly one tvalid=0 bubble cycle between consecutive output frames.
- s00_axis_tready falls the cycle after the closing beat only if the next bank is full.

## Test plan
- 16-word frame, data 1..16, tlast on 16; m00_axis_tready low until 8 cycles after the last input.
  - Required: tvalid high with tdata=1 held stable.
  - Then 16 consecutive beats 1..16, tlast only on 16, tstrb=4'hF.
  - Afterwards tvalid=0 and bank_full=0.
- m00_axis_tready held high; frames 0x10..0x17 (8 words) and 0xA0..0xA3 (4 words) back-to-back.
  - Required: s00_axis_tready never drops.
  - Output is 8 beats then exactly one bubble then 4 beats, tlast on 0x17 and 0xA3.
- DEPTH=16, 20-word frame 1..20 with tlast on 20, followed by a 2-word frame 0x55,0x56.
  - Required: output 1..16 with tlast on 16, and overflow=1 from the edge accepting word 16.
  - Words 17..20 are absent; the next frame outputs 0x55,0x56 exactly.
- m00_axis_tready low; three 4-word frames offered.
  - Required: bank_full=2'b11 after the second frame, and s00_axis_tready=0 during the third.
  - Raise m00_axis_tready: the third frame is accepted only after the first frame's tlast handshake.
  - Toggle m00_axis_tready every cycle: data stays stable while stalled.
- Single-word frame 0xDEADBEEF with tlast: one output beat with tlast=1, len=1.
- areset pulsed for 1 cycle midway through draining a 16-word frame.
  - Required: tvalid=0, bank_full=0 and overflow=0 the next cycle.
  - A following 3-word frame replays correctly.

Source files
------------

// File: rtl/axis_pingpong_frame_buffer.sv
// Two-bank store-and-forward AXI-Stream frame buffer.
// One bank captures the incoming frame while the other replays the previous one.
// Frames longer than DEPTH words are truncated, and the sticky overflow flag is raised.
module axis_pingpong_frame_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tlast,
  input  logic                    s00_axis_tvalid,
  output logic                    s00_axis_tready,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  output logic                    m00_axis_tvalid,
  input  logic                    m00_axis_tready,
  output logic [1:0]              bank_full,
  output logic                    overflow
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LEN_W  = PTR_W + 1;
  localparam int WORD_W = DATA_WIDTH + STRB_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {WR_FILL, WR_DISCARD, WR_WAIT} wrState_t;
  typedef enum logic {RD_IDLE, RD_SEND} rdState_t;

  // Storage: one word holds {strobes, data}.
  logic [WORD_W-1:0] mem_q [2][DEPTH];
  logic [LEN_W-1:0]  lenMem_q [2];

  // Write side state
  wrState_t          wrState_q;
  logic [PTR_W-1:0]  wrPtr_q;
  logic              wrBank_q;
  logic              wrReady_q;
  logic              overflow_q;

  // Read side state
  rdState_t          rdState_q;
  logic [PTR_W-1:0]  rdPtr_q;
  logic              rdBank_q;
  logic              outValid_q;
  logic [DATA_WIDTH-1:0] outData_q;
  logic [STRB_W-1:0] outStrb_q;
  logic              outLast_q;

  // Shared bank occupancy
  logic [1:0]        bankFull_q;
  logic [1:0]        bankFull_d;

  logic              inAccept;
  logic              wrClose;
  logic              rdFree;
  logic [PTR_W-1:0]  rdNextPtr;
  logic [PTR_W-1:0]  rdAddr;
  logic [WORD_W-1:0] rdWord;

  // The ready register is forced low while reset is held so no beat is taken during reset.
  assign s00_axis_tready = wrReady_q && !areset;
  assign inAccept        = s00_axis_tvalid && s00_axis_tready;
  assign wrClose         = (wrState_q == WR_FILL) && inAccept &&
                           (s00_axis_tlast || (wrPtr_q == LAST_PTR));
  assign rdFree          = (rdState_q == RD_SEND) && m00_axis_tready && outLast_q;
  assign rdNextPtr       = rdPtr_q + PTR_W'(1);

  // Next occupancy: a closing write sets its bank, the last output handshake clears the read bank.
  always_comb begin
    bankFull_d = bankFull_q;
    if (wrClose) bankFull_d[wrBank_q] = 1'b1;
    if (rdFree)  bankFull_d[rdBank_q] = 1'b0;
  end

  // Read port: word 0 when starting a frame, otherwise the word after the one being presented.
  always_comb begin
    rdAddr = (rdState_q == RD_IDLE) ? '0 : rdNextPtr;
    rdWord = mem_q[rdBank_q][rdAddr];
  end

  // Capture accepted beats into the bank being filled; discarded beats never reach memory.
  always_ff @(posedge aclk) begin
    if ((wrState_q == WR_FILL) && inAccept) begin
      mem_q[wrBank_q][wrPtr_q] <= {s00_axis_tstrb, s00_axis_tdata};
    end
  end

  // Write FSM: fill the current bank, drop the tail of over-length frames, stall on a full bank.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wrState_q   <= WR_FILL;
      wrPtr_q     <= '0;
      wrBank_q    <= 1'b0;
      wrReady_q   <= 1'b1;
      overflow_q  <= 1'b0;
      lenMem_q[0] <= '0;
      lenMem_q[1] <= '0;
    end else begin
      case (wrState_q)
        WR_FILL: begin
          if (inAccept) begin
            if (wrClose) begin
              lenMem_q[wrBank_q] <= {1'b0, wrPtr_q} + LEN_W'(1);
              wrBank_q <= ~wrBank_q;
              wrPtr_q  <= '0;
              if (!s00_axis_tlast) begin
                overflow_q <= 1'b1;
                wrState_q  <= WR_DISCARD;
                wrReady_q  <= 1'b1;
              end else if (bankFull_d[~wrBank_q]) begin
                wrState_q <= WR_WAIT;
                wrReady_q <= 1'b0;
              end else begin
                wrState_q <= WR_FILL;
                wrReady_q <= 1'b1;
              end
            end else begin
              wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
          end
        end
        WR_DISCARD: begin
          if (inAccept && s00_axis_tlast) begin
            if (bankFull_d[wrBank_q]) begin
              wrState_q <= WR_WAIT;
              wrReady_q <= 1'b0;
            end else begin
              wrState_q <= WR_FILL;
              wrReady_q <= 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (!bankFull_d[wrBank_q]) begin
            wrState_q <= WR_FILL;
            wrReady_q <= 1'b1;
          end
        end
        default: begin
          wrState_q <= WR_FILL;
          wrReady_q <= 1'b1;
        end
      endcase
    end
  end

  // Bank occupancy register, shared handshake point between the two sides.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bankFull_q <= 2'b00;
    end else begin
      bankFull_q <= bankFull_d;
    end
  end

  // Read FSM: prefetch word 0 of a full bank, then stream one word per handshake with no gaps.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdState_q  <= RD_IDLE;
      rdPtr_q    <= '0;
      rdBank_q   <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outStrb_q  <= '0;
      outLast_q  <= 1'b0;
    end else begin
      case (rdState_q)
        RD_IDLE: begin
          if (bankFull_q[rdBank_q]) begin
            outData_q  <= rdWord[DATA_WIDTH-1:0];
            outStrb_q  <= rdWord[WORD_W-1:DATA_WIDTH];
            outLast_q  <= (lenMem_q[rdBank_q] == LEN_W'(1));
            rdPtr_q    <= '0;
            outValid_q <= 1'b1;
            rdState_q  <= RD_SEND;
          end
        end
        RD_SEND: begin
          if (m00_axis_tready) begin
            if (outLast_q) begin
              outValid_q <= 1'b0;
              outLast_q  <= 1'b0;
              rdBank_q   <= ~rdBank_q;
              rdState_q  <= RD_IDLE;
            end else begin
              rdPtr_q   <= rdNextPtr;
              outData_q <= rdWord[DATA_WIDTH-1:0];
              outStrb_q <= rdWord[WORD_W-1:DATA_WIDTH];
              outLast_q <= ({1'b0, rdNextPtr} == (lenMem_q[rdBank_q] - LEN_W'(1)));
            end
          end
        end
        default: begin
          rdState_q  <= RD_IDLE;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m00_axis_tdata  = outData_q;
  assign m00_axis_tstrb  = outStrb_q;
  assign m00_axis_tlast  = outLast_q;
  assign m00_axis_tvalid = outValid_q;
  assign bank_full       = bankFull_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_axis_pingpong_frame_buffer.sv
// Self-checking bench for axis_pingpong_frame_buffer.
// A queue model holds every beat the buffer is expected to replay; a monitor pops it on each output handshake.
module tb_axis_pingpong_frame_buffer;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s00_axis_tdata = '0;
  logic [SW-1:0] s00_axis_tstrb = '0;
  logic          s00_axis_tlast = 1'b0;
  logic          s00_axis_tvalid = 1'b0;
  logic          s00_axis_tready;
  logic [DW-1:0] m00_axis_tdata;
  logic [SW-1:0] m00_axis_tstrb;
  logic          m00_axis_tlast;
  logic          m00_axis_tvalid;
  logic          m00_axis_tready = 1'b0;
  logic [1:0]    bank_full;
  logic          overflow;

  axis_pingpong_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .bank_full       (bank_full),
    .overflow        (overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  typedef struct {
    int            len;
    logic [DW-1:0] base;
    int            expBeats;
    logic          expOvf;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t expQ[$];
  bit    expOvf = 1'b0;
  int    cyc = 0;
  int    beatCyc[$];
  bit    beatLast[$];
  int    inCyc[$];
  int    readyDrops = 0;
  bit    randReady = 1'b0;
  bit    prevStall = 1'b0;
  logic [63:0] savedOut = '0;
  vec_t  vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Cycle counter used to time-stamp handshakes.
  always @(posedge aclk) cyc++;

  // Random downstream backpressure, changed well away from the sampling edge.
  always @(posedge aclk) begin
    #2;
    if (randReady) m00_axis_tready = 1'($urandom_range(0, 1));
  end

  // Input-side observer: handshake times and ready drops while a beat is offered.
  always @(negedge aclk) begin
    if (!areset && s00_axis_tvalid) begin
      if (s00_axis_tready) inCyc.push_back(cyc);
      else readyDrops++;
    end
  end

  // Output monitor: compares every handshake against the model and checks hold-while-stalled.
  always @(negedge aclk) begin
    beat_t e;
    if (areset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("holdValid", 64'(m00_axis_tvalid), 64'd1);
        checkOutput("holdData", 64'({m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}), savedOut);
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedBeat: got 0x%0h, expected no beat", m00_axis_tdata);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat", 64'({m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}), 64'(e));
        end
        beatCyc.push_back(cyc);
        beatLast.push_back(m00_axis_tlast);
      end
      prevStall = m00_axis_tvalid && !m00_axis_tready;
      savedOut  = 64'({m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast});
    end
  end

  task automatic applyReset();
    randReady       = 1'b0;
    areset          = 1'b1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
    m00_axis_tready = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    checkOutput("rstReadyLow", 64'(s00_axis_tready), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    expQ.delete();
    expOvf = 1'b0;
    @(negedge aclk);
    checkOutput("rstReadyHigh", 64'(s00_axis_tready), 64'd1);
    checkOutput("rstValid", 64'(m00_axis_tvalid), 64'd0);
    checkOutput("rstOut", 64'({m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}), 64'd0);
    checkOutput("rstFull", 64'(bank_full), 64'd0);
    checkOutput("rstOvf", 64'(overflow), 64'd0);
    @(posedge aclk); #1;
  endtask

  // Sends one frame and records what the buffer must replay: at most DEPTH words, tlast on the final kept word.
  task automatic applyStimulus(input int len, input logic [DW-1:0] base, input bit randData);
    logic [DW-1:0] d[$];
    logic [SW-1:0] s[$];
    beat_t b;
    int kept;
    int waited;
    bit wasOvf;
    for (int i = 0; i < len; i++) begin
      d.push_back(randData ? DW'($urandom) : base + DW'(i));
      s.push_back(randData ? SW'($urandom) : '1);
    end
    kept = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < kept; i++) begin
      b.data = d[i];
      b.strb = s[i];
      b.last = (i == kept - 1);
      expQ.push_back(b);
    end
    wasOvf = expOvf;
    if (len > DEPTH) expOvf = 1'b1;
    for (int i = 0; i < len; i++) begin
      s00_axis_tdata  = d[i];
      s00_axis_tstrb  = s[i];
      s00_axis_tlast  = (i == len - 1);
      s00_axis_tvalid = 1'b1;
      waited = 0;
      @(negedge aclk);
      while (!s00_axis_tready && waited < 1000) begin
        @(negedge aclk);
        waited++;
      end
      if (!s00_axis_tready) begin
        checks++;
        errors++;
        $display("[TB] FAIL inputTimeout: got tready=0 for %0d cycles, expected acceptance", waited);
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        return;
      end
      @(posedge aclk); #1;
      if (len > DEPTH && i == DEPTH - 2 && !wasOvf) checkOutput("ovfEarly", 64'(overflow), 64'd0);
      if (len > DEPTH && i == DEPTH - 1) checkOutput("ovfSet", 64'(overflow), 64'd1);
    end
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    @(negedge aclk);
    while (!(expQ.size() == 0 && !m00_axis_tvalid) && n < 4000) begin
      @(negedge aclk);
      n++;
    end
    if (expQ.size() != 0 || m00_axis_tvalid) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d beats pending, expected 0", expQ.size());
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int span, lasts, gap, run1, run2, lastCyc, n;
    bit frame3Done;

    vecs[0] = '{1,  32'hDEADBEEF, 1,  1'b0};
    vecs[1] = '{16, 32'h00000001, 16, 1'b0};
    vecs[2] = '{20, 32'h00000001, 16, 1'b1};
    vecs[3] = '{17, 32'h00000040, 16, 1'b1};
    vecs[4] = '{15, 32'h00000060, 15, 1'b0};
    vecs[5] = '{2,  32'h00000080, 2,  1'b0};

    // Table-driven single frames with free-running downstream.
    $display("[TB] table vectors");
    for (int v = 0; v < 6; v++) begin
      applyReset();
      m00_axis_tready = 1'b1;
      beatCyc.delete();
      beatLast.delete();
      applyStimulus(vecs[v].len, vecs[v].base, 1'b0);
      waitDrain();
      checkOutput("vecBeats", 64'(beatCyc.size()), 64'(vecs[v].expBeats));
      checkOutput("vecOvf", 64'(overflow), 64'(vecs[v].expOvf));
      checkOutput("vecLast", 64'((beatLast.size() > 0) ? beatLast[beatLast.size()-1] : 1'b0), 64'd1);
      checkOutput("vecFull", 64'(bank_full), 64'd0);
    end

    // Stalled 16-word frame, then released.
    $display("[TB] stalled full frame");
    applyReset();
    beatCyc.delete();
    beatLast.delete();
    applyStimulus(16, 32'd1, 1'b0);
    repeat (8) @(negedge aclk);
    checkOutput("stallValid", 64'(m00_axis_tvalid), 64'd1);
    checkOutput("stallData", 64'(m00_axis_tdata), 64'd1);
    @(posedge aclk); #1;
    m00_axis_tready = 1'b1;
    waitDrain();
    span = (beatCyc.size() == 16) ? beatCyc[15] - beatCyc[0] : -1;
    lasts = 0;
    foreach (beatLast[i]) if (beatLast[i]) lasts++;
    checkOutput("fullBeats", 64'(beatCyc.size()), 64'd16);
    checkOutput("fullSpan", 64'(span), 64'd15);
    checkOutput("fullLasts", 64'(lasts), 64'd1);
    checkOutput("fullDrained", 64'(bank_full), 64'd0);

    // Back-to-back 8- and 4-word frames: no input stall, one bubble between outputs.
    $display("[TB] back-to-back frames");
    applyReset();
    m00_axis_tready = 1'b1;
    readyDrops = 0;
    beatCyc.delete();
    beatLast.delete();
    applyStimulus(8, 32'h10, 1'b0);
    applyStimulus(4, 32'hA0, 1'b0);
    waitDrain();
    gap = -1; run1 = -1; run2 = -1;
    if (beatCyc.size() == 12) begin
      run1 = beatCyc[7] - beatCyc[0];
      gap  = beatCyc[8] - beatCyc[7];
      run2 = beatCyc[11] - beatCyc[8];
    end
    checkOutput("b2bDrops", 64'(readyDrops), 64'd0);
    checkOutput("b2bBeats", 64'(beatCyc.size()), 64'd12);
    checkOutput("b2bRun1", 64'(run1), 64'd7);
    checkOutput("b2bGap", 64'(gap), 64'd2);
    checkOutput("b2bRun2", 64'(run2), 64'd3);
    checkOutput("b2bLast1", 64'((beatLast.size() == 12) ? beatLast[7] : 1'b0), 64'd1);

    // Over-length frame followed by a short one.
    $display("[TB] truncation");
    applyReset();
    m00_axis_tready = 1'b1;
    beatCyc.delete();
    beatLast.delete();
    applyStimulus(20, 32'd1, 1'b0);
    applyStimulus(2, 32'h55, 1'b0);
    waitDrain();
    checkOutput("truncBeats", 64'(beatCyc.size()), 64'd18);
    checkOutput("truncOvf", 64'(overflow), 64'd1);

    // Both banks full, third frame held off until the first drains, toggling backpressure.
    $display("[TB] both banks full");
    applyReset();
    applyStimulus(4, 32'h100, 1'b0);
    applyStimulus(4, 32'h200, 1'b0);
    @(negedge aclk);
    checkOutput("bothFull", 64'(bank_full), 64'd3);
    checkOutput("waitReady", 64'(s00_axis_tready), 64'd0);
    inCyc.delete();
    beatCyc.delete();
    beatLast.delete();
    frame3Done = 1'b0;
    fork
      begin
        applyStimulus(4, 32'h300, 1'b0);
        frame3Done = 1'b1;
      end
    join_none
    repeat (5) @(negedge aclk);
    checkOutput("noEarlyAccept", 64'(inCyc.size()), 64'd0);
    for (int i = 0; i < 80 && !(frame3Done && expQ.size() == 0); i++) begin
      @(posedge aclk); #1;
      m00_axis_tready = ~m00_axis_tready;
    end
    m00_axis_tready = 1'b1;
    n = 0;
    while (!frame3Done && n < 2000) begin
      @(posedge aclk); #1;
      n++;
    end
    waitDrain();
    lastCyc = -1;
    foreach (beatLast[i]) if (beatLast[i] && lastCyc < 0) lastCyc = beatCyc[i];
    checkOutput("acceptAfterDrain", 64'((inCyc.size() > 0 && lastCyc >= 0) ? (inCyc[0] > lastCyc) : 1'b0), 64'd1);
    checkOutput("threeFrames", 64'(beatCyc.size()), 64'd12);

    // Reset pulse while draining an over-length frame, then a clean 3-word frame.
    $display("[TB] reset mid-drain");
    applyReset();
    m00_axis_tready = 1'b1;
    applyStimulus(20, 32'h1000, 1'b0);
    repeat (4) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    expQ.delete();
    expOvf = 1'b0;
    @(negedge aclk);
    checkOutput("midRstValid", 64'(m00_axis_tvalid), 64'd0);
    checkOutput("midRstFull", 64'(bank_full), 64'd0);
    checkOutput("midRstOvf", 64'(overflow), 64'd0);
    @(posedge aclk); #1;
    beatCyc.delete();
    beatLast.delete();
    applyStimulus(3, 32'h77, 1'b0);
    waitDrain();
    checkOutput("postRstBeats", 64'(beatCyc.size()), 64'd3);

    // Randomized frames and backpressure against the queue model.
    $display("[TB] random traffic");
    applyReset();
    randReady = 1'b1;
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      #1;
      applyStimulus($urandom_range(1, 20), '0, 1'b1);
    end
    @(posedge aclk); #1;
    randReady = 1'b0;
    m00_axis_tready = 1'b1;
    waitDrain();
    checkOutput("randOvf", 64'(overflow), 64'(expOvf));
    checkOutput("randFull", 64'(bank_full), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
